pipe_addsub: RTL and testbench
==============================

# pipe_addsub

Parametrised, pipelined adder/subtractor; next generation of the team's chunked ripple-carry adders. Operands are split into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. This gives full throughput at a clock rate set by one CHUNK-bit ripple. It sits between operand producers and result consumers, using a valid/ready handshake on both sides.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per stage; STAGES = WIDTH/CHUNK.
- Clk  in  1  clock; all logic on the rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- InValid  in  1  operand beat valid.
- InReady  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIn  in  1  carry-in; ignored when Sub=1.
- Sub  in  1  0 means A+B+CIn; 1 means A-B, computed as A+~B+1.
- OutValid  out  1  result beat valid.
- OutReady  in  1  consumer accepts the result.
- S  out  WIDTH  sum or difference.
- COut  out  1  carry-out of the MSB. For Sub it is 1 when there is no borrow (A>=B unsigned).
- Ovf  out  1  signed overflow; present only with PIPE_ADDSUB_OVF_EN.

## Operation
- Beat accepted when InValid && InReady.
- Stage k (0..STAGES-1) adds slice k of A and of B' using the carry registered by stage k-1. B' = Sub ? ~B : B.
  - Stage 0 carry-in = Sub ? 1 : CIn.
- Operand skew: slices not yet consumed travel forward in registers alongside the beat.
- Result deskew: slices already computed also travel forward, so S emerges aligned in the final stage.
- Every stage holds a valid bit. Beats never reorder, drop or duplicate.
- Global advance enable: Adv = !OutValid || OutReady.
  - InReady = Adv.
  - When Adv=0, every stage register holds. Bubbles are not compressed; this keeps the design a simple lock-step pipeline.
- The final stage register drives S, COut, OutValid and Ovf directly; there is no output combinational logic.
- Arithmetic is modulo 2^WIDTH. COut is the carry out of bit WIDTH-1.
- Sub is captured with the beat and travels with it, so mixed add/sub streams are legal.

## Timing
- Latency: a beat accepted at edge n appears with OutValid=1 after edge n+STAGES, provided no stall occurs.
- Throughput: 1 beat/cycle while OutReady=1.
- Stall: while OutValid=1 && OutReady=0, S, COut and Ovf stay stable and InReady=0 in the same cycle (combinational from OutReady).
- Simultaneous output pop and input push while full: both occur; there is no bubble.
- Reset, including mid-stream: all valid bits, S, COut and Ovf clear to 0 on the edge where Rst_n=0. In-flight beats are discarded. InReady=1 in the first cycle after reset.
- OutValid=0 while the pipe is empty. The values of S and COut are don't-care when OutValid=0 but must not contain X after reset.

## Configuration
- PIPE_ADDSUB_OVF_EN defined:
  - Ovf port exists.
  - Ovf = carry into MSB XOR carry out of MSB, registered with the final stage and reset to 0.
- Undefined: Ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package pipe_addsub_pkg: localparam function computing STAGES; typedef for the per-stage valid/carry/sub bundle; default WIDTH and CHUNK constants.
- One sub-module, chunk_adder: a combinational CHUNK-bit ripple adder (inputs a, b, cin; outputs s, cout). It is instantiated STAGES times in a generate loop. Registers live only in pipe_addsub.
- Static assertion (simulation only): WIDTH % CHUNK == 0.

## Test plan
All scenarios use WIDTH=16 and CHUNK=4, so latency is 4.
- Add wrap: A=0xFFFF, B=0x0001, CIn=0, Sub=0 -> 4 cycles later S=0x0000, COut=1, Ovf=0.
- Subtract with borrow: A=0x0005, B=0x0007, Sub=1 -> S=0xFFFE, COut=0, Ovf=0. Then A=0x8000, B=0x0001, Sub=1 -> S=0x7FFF, COut=1, Ovf=1.
- Signed overflow add: A=0x7FFF, B=0x0001, CIn=0 -> S=0x8000, COut=0, Ovf=1.
- Streaming: 8 back-to-back beats A=i, B=0x0100*i, alternating Sub, OutReady=1 -> 8 results on consecutive cycles, in order, each matching the reference model.
- Backpressure: OutReady held 0 for 3 cycles with the pipe full -> InReady=0 throughout, S stable. After release, all beats arrive with none lost or duplicated.
- Reset mid-stream: Rst_n=0 for 1 cycle while 3 beats are in flight -> next cycle OutValid=0, S=0, COut=0, InReady=1. No stale beat ever appears at the output.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipe_addsub_pkg
// Shared constants, types and helpers for the pipelined adder/subtractor.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits resolved per stage
//   calc_stages()         : number of pipeline stages for a WIDTH/CHUNK pair
//   stage_ctl_t           : per-stage valid / carry / sub bundle
// Optional feature macro: PIPE_ADDSUB_OVF_EN (see pipe_addsub.sv).
// -----------------------------------------------------------------------------
package pipe_addsub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_addsub_if.sv
// -----------------------------------------------------------------------------
// pipe_addsub_if
// Operand / result handshake bundle for pipe_addsub.
//   InValid, InReady, A, B, CIn, Sub : operand side (producer -> adder)
//   OutValid, OutReady, S, COut, Ovf : result side (adder -> consumer)
// modport slave  : the adder
// modport master : the environment driving operands and accepting results
// Ovf exists only when PIPE_ADDSUB_OVF_EN is defined.
// -----------------------------------------------------------------------------
interface pipe_addsub_if #(
    parameter int WIDTH = pipe_addsub_pkg::DEF_WIDTH
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIn;
    logic             Sub;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] S;
    logic             COut;
`ifdef PIPE_ADDSUB_OVF_EN
    logic             Ovf;

    modport slave (
        input  InValid, A, B, CIn, Sub, OutReady,
        output InReady, OutValid, S, COut, Ovf
    );
    modport master (
        output InValid, A, B, CIn, Sub, OutReady,
        input  InReady, OutValid, S, COut, Ovf
    );
`else
    modport slave (
        input  InValid, A, B, CIn, Sub, OutReady,
        output InReady, OutValid, S, COut
    );
    modport master (
        output InValid, A, B, CIn, Sub, OutReady,
        input  InReady, OutValid, S, COut
    );
`endif
endinterface

// File: rtl/pipe_addsub_chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple-carry adder, one per pipeline stage.
//   a, b : CHUNK-bit addends
//   cin  : carry in
//   s    : CHUNK-bit sum
//   cout : carry out of the top bit
// -----------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined adder/subtractor. Operands are captured into an input row, then
// resolved CHUNK bits per stage with the carry registered between stages.
// The final row register drives the result outputs directly.
//   Clk   : clock, rising edge
//   Rst_n : synchronous active-low reset
//   bus   : pipe_addsub_if.slave (operand and result handshakes)
// Optional: define PIPE_ADDSUB_OVF_EN to add the registered signed-overflow
// output bus.Ovf.
//
// Row layout (STAGES rows feed the adders, one output row after them):
//   w_q[k]  : low CHUNK bits are the A slice for stage k; finished sum slices
//             are rotated in at the top, so after the last stage the word is S
//   b_q     : triangular store of unconsumed B slices, row k holds
//             WIDTH-k*CHUNK bits
// -----------------------------------------------------------------------------
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic         Clk,
    input  logic         Rst_n,
    pipe_addsub_if.slave bus
);

    // Offset of row k inside the triangular B store.
    function automatic int b_off(input int k);
        return k * WIDTH - (CHUNK * k * (k - 1)) / 2;
    endfunction

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int B_TOT  = b_off(STAGES);

    if (WIDTH % CHUNK != 0) begin : g_chk_div
        $error("pipe_addsub: WIDTH must be a multiple of CHUNK");
    end
    if (STAGES < 2) begin : g_chk_stages
        $error("pipe_addsub: WIDTH must span at least two chunks");
    end
    if ($bits(bus.A) != WIDTH) begin : g_chk_bus
        $error("pipe_addsub: interface WIDTH differs from module WIDTH");
    end

    logic                           adv;
    stage_ctl_t [STAGES-1:0]        ctl_q, ctl_d;
    logic [STAGES-1:0][WIDTH-1:0]   w_q, w_d;
    logic [B_TOT-1:0]               b_q, b_d;
    logic [STAGES-1:0][CHUNK-1:0]   sum;
    logic [STAGES-1:0]              cout;

    logic                           out_valid_q, out_valid_d;
    logic [WIDTH-1:0]               s_q, s_d;
    logic                           cout_q, cout_d;
`ifdef PIPE_ADDSUB_OVF_EN
    logic                           ovf_q, ovf_d;
`endif

    // Lock-step pipe: everything moves together or everything holds.
    assign adv         = !out_valid_q || bus.OutReady;
    assign bus.InReady = adv;

    // Input row. Stage 0 carry-in is forced to 1 for subtraction (A + ~B + 1).
    assign ctl_d[0]        = '{valid: bus.InValid, carry: bus.Sub | bus.CIn, sub: bus.Sub};
    assign w_d[0]          = bus.A;
    assign b_d[0 +: WIDTH] = bus.B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int OFF = b_off(k);
        localparam int RW  = WIDTH - k * CHUNK;

        logic [CHUNK-1:0] b_slice;

        assign b_slice = ctl_q[k].sub ? ~b_q[OFF +: CHUNK] : b_q[OFF +: CHUNK];

        chunk_adder #(
            .CHUNK (CHUNK)
        ) u_add (
            .a    (w_q[k][CHUNK-1:0]),
            .b    (b_slice),
            .cin  (ctl_q[k].carry),
            .s    (sum[k]),
            .cout (cout[k])
        );

        if (k < STAGES - 1) begin : g_fwd
            assign ctl_d[k+1] = '{valid: ctl_q[k].valid, carry: cout[k], sub: ctl_q[k].sub};
            assign w_d[k+1]   = {sum[k], w_q[k][WIDTH-1:CHUNK]};
            assign b_d[b_off(k+1) +: RW-CHUNK] = b_q[OFF+CHUNK +: RW-CHUNK];
        end else begin : g_last
            assign out_valid_d = ctl_q[k].valid;
            assign s_d         = {sum[k], w_q[k][WIDTH-1:CHUNK]};
            assign cout_d      = cout[k];
`ifdef PIPE_ADDSUB_OVF_EN
            // Carry into the MSB recovered from the MSB's own sum bit.
            assign ovf_d = (w_q[k][CHUNK-1] ^ b_slice[CHUNK-1] ^ sum[k][CHUNK-1]) ^ cout[k];
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ctl_q       <= '0;
            w_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
`ifdef PIPE_ADDSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (adv) begin
            ctl_q       <= ctl_d;
            w_q         <= w_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
`ifdef PIPE_ADDSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.OutValid = out_valid_q;
    assign bus.S        = s_q;
    assign bus.COut     = cout_q;
`ifdef PIPE_ADDSUB_OVF_EN
    assign bus.Ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_addsub
// Self-checking bench for pipe_addsub (WIDTH=16, CHUNK=4). A reference model
// computes each result arithmetically; in-flight beats are tracked as a queue
// of results with their age in advance steps, visible at age STAGES.
// Honors PIPE_ADDSUB_OVF_EN for the Ovf checks.
// -----------------------------------------------------------------------------
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int STAGES = calc_stages(16, 4);

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          age;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    pipe_addsub_if #(.WIDTH(16)) bus ();

    pipe_addsub #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pushed  = 0;
    int          popped  = 0;
    int          dropped = 0;
    exp_t        q[$];
    logic [15:0] last_s;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int   ur;
        int   sr;
        if (sub) begin
            ur  = int'(a) - int'(b);
            sr  = int'($signed(a)) - int'($signed(b));
            e.c = (a >= b);
        end else begin
            ur  = int'(a) + int'(b) + int'(cin);
            sr  = int'($signed(a)) + int'($signed(b)) + int'(cin);
            e.c = (ur > 65535);
        end
        e.s   = ur[15:0];
        e.o   = (sr > 32767) || (sr < -32768);
        e.age = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, clock, update model.
    task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic ordy);
        logic exp_ov;
        logic exp_ir;
        bus.InValid  = v;
        bus.A        = a;
        bus.B        = b;
        bus.CIn      = cin;
        bus.Sub      = sub;
        bus.OutReady = ordy;
        #1;
        exp_ov = (q.size() > 0) && (q[0].age == STAGES);
        chk("out_valid", bus.OutValid, exp_ov);
        if (exp_ov) begin
            chk("s", bus.S, q[0].s);
            chk("cout", bus.COut, q[0].c);
`ifdef PIPE_ADDSUB_OVF_EN
            chk("ovf", bus.Ovf, q[0].o);
`endif
        end
        exp_ir = !exp_ov || ordy;
        chk("in_ready", bus.InReady, exp_ir);
        last_s = bus.S;
        @(posedge Clk);
        if (!Rst_n) begin
            dropped += q.size();
            q.delete();
        end else if (exp_ir) begin
            if (exp_ov) begin
                void'(q.pop_front());
                popped++;
            end
            foreach (q[i]) q[i].age++;
            if (v) begin
                q.push_back(model(a, b, cin, sub));
                pushed++;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, ordy);
    endtask

    task automatic send_expect(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub,
                               input logic [15:0] es, input logic ec, input logic eo);
        int k;
        cyc(1'b1, a, b, cin, sub, 1'b1);
        k = 0;
        while (!bus.OutValid && k < 12) begin
            idle(1'b1);
            k++;
        end
        chk({tag, "_latency"}, k, STAGES);
        chk({tag, "_s"}, bus.S, es);
        chk({tag, "_cout"}, bus.COut, ec);
`ifdef PIPE_ADDSUB_OVF_EN
        chk({tag, "_ovf"}, bus.Ovf, eo);
`else
        if (eo === 1'bx) $display("unreachable");
`endif
        idle(1'b1);
    endtask

    initial begin
        int p0;
        logic [15:0] hold;

        Rst_n        = 1'b0;
        bus.InValid  = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.CIn      = 1'b0;
        bus.Sub      = 1'b0;
        bus.OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        #1;
        chk("rst_out_valid", bus.OutValid, 1'b0);
        chk("rst_s", bus.S, 16'h0000);
        chk("rst_cout", bus.COut, 1'b0);
        chk("rst_in_ready", bus.InReady, 1'b1);
`ifdef PIPE_ADDSUB_OVF_EN
        chk("rst_ovf", bus.Ovf, 1'b0);
`endif
        @(posedge Clk);
        #1;

        // Directed boundary vectors
        send_expect("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_expect("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_expect("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_expect("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_expect("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        send_expect("sub_cin_ignored", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Streaming: 8 back-to-back beats, alternating add/sub
        p0 = popped;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 16'(i), 16'(i * 256), 1'b0, 1'(i % 2), 1'b1);
        end
        repeat (STAGES + 1) idle(1'b1);
        chk("stream_pops", popped - p0, 8);

        // Backpressure with the pipe full
        p0 = popped;
        for (int i = 0; i < STAGES + 1; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1);
        end
        hold = bus.S;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
            chk("stall_s_stable", bus.S, hold);
            chk("stall_in_ready", bus.InReady, 1'b0);
        end
        repeat (STAGES + 4) idle(1'b1);
        chk("bp_pops", popped - p0, STAGES + 1);

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        end
        Rst_n = 1'b0;
        cyc(1'b1, 16'h00AA, 16'h0055, 1'b0, 1'b0, 1'b1);
        Rst_n = 1'b1;
        bus.OutReady = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.OutValid, 1'b0);
        chk("mid_rst_s", bus.S, 16'h0000);
        chk("mid_rst_cout", bus.COut, 1'b0);
        chk("mid_rst_in_ready", bus.InReady, 1'b1);
`ifdef PIPE_ADDSUB_OVF_EN
        chk("mid_rst_ovf", bus.Ovf, 1'b0);
`endif
        repeat (STAGES + 4) idle(1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
        end
        repeat (STAGES + 8) idle(1'b1);
        chk("all_beats_delivered", popped, pushed - dropped);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
